// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the receiver FSM.
package uart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF   = 115_200;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_buf_if.sv
// Read-side handshake and status pulses of the buffered UART receiver.
interface uart_rx_buf_if;
  import uart_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;
  logic              overrun;

  modport master (output rd_valid, rd_data, frame_err, overrun, input rd_ready);
  modport slave  (input rd_valid, rd_data, frame_err, overrun, output rd_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered storage, combinational head read, simultaneous
// push and pop always succeed (including when full).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign count     = count_q;
  assign rd_data_c = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot the push writes into.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// valid/ready byte FIFO with frame-error and overrun pulses.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk_50m,
  input  logic          sw_rst_n,
  input  logic          uart_rx,
  uart_rx_buf_if.master rd_if
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  // Counter runs down to zero; a reload of DIV-1 spaces samples DIV cycles apart.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  logic              rx_prev_q;

  uart_rx_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              expire;
  logic              push_c;
  logic              ferr_c;

  logic              frame_err_q;
  logic              overrun_q;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Two-flop synchronizer, idle-high so reset never looks like a start edge.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_s   = sync_q[1];
  assign expire = (cnt_q == CNT_W'(0));

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = expire ? cnt_q : cnt_q - CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = BIT_LOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          cnt_d   = BIT_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (expire) begin
          cnt_d = BIT_LOAD;
          if ((^shift_q) != rx_s) begin
            ferr_c  = 1'b1;
            state_d = WAIT_IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (expire) begin
          if (rx_s) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = rd_if.rd_ready & ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_50m),
    .rst_n     (sw_rst_n),
    .push      (push_c),
    .push_data (shift_q),
    .pop       (fifo_pop),
    .rd_data_c (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Status pulses, one cycle after the sample that caused them.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_c;
      overrun_q   <= push_c & fifo_full & ~fifo_pop;
    end
  end

  assign rd_if.rd_valid  = (fifo_count != FCNT_W'(0));
  assign rd_if.rd_data   = rd_if.rd_valid ? fifo_head : '0;
  assign rd_if.frame_err = frame_err_q;
  assign rd_if.overrun   = overrun_q;

endmodule
